// File: rtl/tilelink_ul_host_arbiter_pkg.sv
// Shared TL-UL types for the host arbiter slice.
// Provides the A/D channel structs (host-to-slave and slave-to-host), the opcode
// enums, the arbiter FSM state enum and the supported host-count ceiling.
package tilelink_ul_host_arbiter_pkg;

    localparam int TL_AW  = 32;  // address width
    localparam int TL_DW  = 32;  // data width
    localparam int TL_DBW = 4;   // byte lanes
    localparam int TL_AIW = 8;   // source id width
    localparam int TL_SZW = 2;   // size field width
    localparam int TL_DIW = 1;   // sink id width

    localparam int TL_ARB_MAX_HOSTS = 16;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_m2s_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_s2m_t;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbAddr,
        ArbResp
    } tl_arb_state_e;

endpackage

// File: rtl/tilelink_ul_host_arbiter_rr_picker.sv
// Combinational round-robin priority picker.
// Returns the first set request at or after ptr_i, wrapping past the top.
//   req_i   in  NumHosts  request vector
//   ptr_i   in  IdxW      highest-priority index
//   valid_o out 1         any request set
//   idx_o   out IdxW      winning index (0 when valid_o=0)
module tl_rr_picker #(
    parameter int NumHosts = 2,
    parameter int IdxW     = 1
) (
    input  logic [NumHosts-1:0] req_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic                valid_o,
    output logic [IdxW-1:0]     idx_o
);

    logic [2*NumHosts-1:0] req_dbl;
    logic                  found;

    // Doubling the request vector turns the wrap-around search into a linear
    // scan over the window [ptr, ptr+NumHosts).
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req_dbl = {req_i, req_i};
        valid_o = |req_i;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < 2*NumHosts; i++) begin
            if (!found && req_dbl[i] && (i >= int'(ptr_i)) && (i < int'(ptr_i) + NumHosts)) begin
                found = 1'b1;
                idx_o = (i >= NumHosts) ? IdxW'(i - NumHosts) : IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/tilelink_ul_host_arbiter.sv
// Shares one TL-UL slave (the TL-UL->AHB bridge) between NumHosts TL-UL hosts.
// Round-robin, one transaction in flight: the grant is held from A accept through
// the D handshake, so D beats route to the owner without rewriting a_source.
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   tl_h_i   in   host requests (A channel + d_ready), one per host
//   tl_h_o   out  host responses (a_ready + D channel), one per host
//   tl_b_o   out  to bridge tl_i
//   tl_b_i   in   from bridge tl_o
//   grant_o  out  one-hot current owner, 0 when idle
//   busy_o   out  transaction in flight
module tilelink_ul_host_arbiter
    import tilelink_ul_host_arbiter_pkg::*;
#(
    parameter  int NumHosts = 2,
    localparam int IdxW     = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tl_m2s_t             tl_h_i [NumHosts],
    output tl_s2m_t             tl_h_o [NumHosts],
    output tl_m2s_t             tl_b_o,
    input  tl_s2m_t             tl_b_i,
    output logic [NumHosts-1:0] grant_o,
    output logic                busy_o
);

    if (NumHosts < 1 || NumHosts > TL_ARB_MAX_HOSTS) begin : g_bad_num_hosts
        $error("NumHosts out of range");
    end

    tl_arb_state_e       state_q, state_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic [IdxW-1:0]     ptr_next, pick_ptr, pick_idx;
    logic [NumHosts-1:0] req;
    logic                pick_valid;
    logic                a_hs, d_hs;

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            req[i] = tl_h_i[i].a_valid;
        end
    end

    // Explicit wrap keeps non-power-of-two host counts in range.
    assign ptr_next = (grant_q == IdxW'(NumHosts - 1)) ? '0 : grant_q + 1'b1;

    assign a_hs = (state_q == ArbAddr) && tl_h_i[grant_q].a_valid && tl_b_i.a_ready;
    assign d_hs = (state_q == ArbResp) && tl_b_i.d_valid && tl_h_i[grant_q].d_ready;

    // On the closing D beat, search from the advanced pointer so the owner that
    // just finished gets lowest priority in the same-cycle re-arbitration.
    assign pick_ptr = d_hs ? ptr_next : rr_q;

    tl_rr_picker #(
        .NumHosts (NumHosts),
        .IdxW     (IdxW)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        unique case (state_q)
            ArbIdle: begin
                if (pick_valid) begin
                    state_d = ArbAddr;
                    grant_d = pick_idx;
                end
            end
            ArbAddr: begin
                if (a_hs) state_d = ArbResp;
            end
            ArbResp: begin
                if (d_hs) begin
                    rr_d = ptr_next;
                    if (pick_valid) begin
                        state_d = ArbAddr;
                        grant_d = pick_idx;
                    end else begin
                        state_d = ArbIdle;
                    end
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ArbIdle;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // Bridge D is only accepted in RESP; a stray beat elsewhere simply stalls.
    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = '0;
        end
        tl_b_o = '0;
        unique case (state_q)
            ArbAddr: begin
                tl_b_o                 = tl_h_i[grant_q];
                tl_b_o.d_ready         = 1'b0;
                tl_h_o[grant_q].a_ready = tl_b_i.a_ready;
            end
            ArbResp: begin
                tl_h_o[grant_q]         = tl_b_i;
                tl_h_o[grant_q].a_ready = 1'b0;
                tl_b_o.d_ready          = tl_h_i[grant_q].d_ready;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != ArbIdle);
    assign grant_o = busy_o ? (NumHosts'(1) << grant_q) : '0;

endmodule
